// File: rtl/controle_injecao_pkg.sv
// controle_injecao_pkg: shared states, step constants and mapa_falhas index helper for the fault-injection campaign
package controle_injecao_pkg;
  typedef enum logic [2:0] {IDLE, APLICA, ESPERA, AMOSTRA, FIM} estado_t;
  localparam int NUM_POS = 15;
  localparam int IDX_BASE = 15;
  localparam int NUM_PASSOS = NUM_POS + 1;
  // step 0 is the baseline and reports on bit IDX_BASE; step s reports on bit s-1
  function automatic logic [3:0] idx_mapa(input logic [3:0] passo);
    return (passo == 4'd0) ? 4'(IDX_BASE) : passo - 4'd1;
  endfunction
endpackage

// File: rtl/contador_espera.sv
// contador_espera: loadable down-counter with zero flag that times the decoder settle wait
module contador_espera (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] valor,
  output logic       zero
);
  logic [3:0] cnt;
  assign zero = (cnt == 4'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= valor;
    else if (en && !zero) cnt <= cnt - 4'd1;
endmodule

// File: rtl/controle_injecao.sv
// controle_injecao: sweeps a baseline plus 15 single-bit injections and records decoder mismatches.
// Optional result log ports (res_valid/res_pos/res_ok) exist only with CONTROLE_INJECAO_LOG_EN defined.
module controle_injecao
  import controle_injecao_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cancelar,
  input  logic [10:0] palavra,
  input  logic [10:0] dec_dado,
  output logic [10:0] dado_teste,
  output logic [3:0]  n,
  output logic        erro,
  output logic        busy,
  output logic        done,
  output logic [4:0]  falhas,
  output logic [15:0] mapa_falhas
`ifdef CONTROLE_INJECAO_LOG_EN
  ,
  output logic        res_valid,
  output logic [3:0]  res_pos,
  output logic        res_ok
`endif
);
  estado_t estado, prox;
  logic [3:0] passo;
  logic cnt_zero, aceita, amostra, falha, ativo;
  assign aceita = (estado == IDLE) && start && !cancelar;
  assign amostra = (estado == AMOSTRA) && !cancelar;
  assign falha = (dec_dado != dado_teste);
  contador_espera u_espera (
    .clk  (clk),
    .rst_n(rst_n),
    .load (estado == APLICA),
    .en   (estado == ESPERA),
    .valor(4'(SETTLE - 1)),
    .zero (cnt_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) estado <= IDLE;
    else estado <= prox;
  always_comb begin
    prox = estado;
    ativo = (estado == APLICA) || (estado == ESPERA) || (estado == AMOSTRA);
    erro = ativo && (passo != 4'd0);
    n = erro ? passo - 4'd1 : 4'd0;
    busy = (estado != IDLE);
    done = (estado == FIM);
    if (estado != IDLE && cancelar) prox = IDLE;
    else
      case (estado)
        IDLE:    prox = aceita ? APLICA : IDLE;
        APLICA:  prox = ESPERA;
        ESPERA:  prox = cnt_zero ? AMOSTRA : ESPERA;
        AMOSTRA: prox = (passo == 4'(NUM_PASSOS - 1)) ? FIM : APLICA;
        default: prox = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      passo <= '0;
      dado_teste <= '0;
      falhas <= '0;
      mapa_falhas <= '0;
    end else if (aceita) begin
      passo <= '0;
      dado_teste <= palavra;
      falhas <= '0;
      mapa_falhas <= '0;
    end else if (amostra) begin
      passo <= passo + 4'd1;
      if (falha) begin
        falhas <= falhas + 5'd1;
        mapa_falhas[idx_mapa(passo)] <= 1'b1;
      end
    end
`ifdef CONTROLE_INJECAO_LOG_EN
  assign res_valid = (estado == AMOSTRA);
  assign res_pos = idx_mapa(passo);
  assign res_ok = !falha;
`endif
endmodule

// File: tb/tb_controle_injecao.sv
// tb_controle_injecao: randomized campaigns against a step/position reference model with directed cancel/reset cases
module tb_controle_injecao;
  localparam int SETTLE = 2;
  localparam int PER = SETTLE + 2;
  localparam int TOTAL = 16 * PER;
  logic clk = 0, rst_n = 0, start = 0, cancelar = 0, zero_mode = 0;
  logic [10:0] palavra = '0, dec_dado, dado_teste;
  logic [3:0] n;
  logic erro, busy, done;
  logic [4:0] falhas;
  logic [15:0] mapa_falhas, mask = '0;
  int checks = 0, failures = 0;
`ifdef CONTROLE_INJECAO_LOG_EN
  logic res_valid, res_ok;
  logic [3:0] res_pos;
`endif
  controle_injecao #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancelar(cancelar), .palavra(palavra),
    .dec_dado(dec_dado), .dado_teste(dado_teste), .n(n), .erro(erro), .busy(busy),
    .done(done), .falhas(falhas), .mapa_falhas(mapa_falhas)
`ifdef CONTROLE_INJECAO_LOG_EN
    , .res_valid(res_valid), .res_pos(res_pos), .res_ok(res_ok)
`endif
  );
  always #5 clk = ~clk;
  // decoder model: corrupts its output whenever the position under test is set in mask
  assign dec_dado = zero_mode ? 11'd0 : (mask[erro ? n : 4'd15] ? ~dado_teste : dado_teste);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic campanha(input logic [10:0] w, input logic [15:0] exp_mapa, input int sp);
    int got = -1;
    int nlog = 0;
    @(negedge clk);
    palavra = w; start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 1; k <= TOTAL + 5; k++) begin
      int st = (k - 1) / PER;
      logic fim = (k == TOTAL + 1);
      chk("busy", busy, 1);
      chk("done", done, fim);
      chk("erro", erro, !fim && st > 0);
      chk("n", n, (!fim && st > 0) ? st - 1 : 0);
      chk("dado_teste", dado_teste, w);
`ifdef CONTROLE_INJECAO_LOG_EN
      if (res_valid) begin
        logic [3:0] pe = (nlog == 0) ? 4'd15 : 4'(nlog - 1);
        chk("res_pos", res_pos, pe);
        chk("res_ok", res_ok, !exp_mapa[pe]);
        nlog++;
      end
`endif
      if (done) begin got = k; break; end
      if (k == sp) begin start = 1; palavra = ~w; end
      if (k == sp + 1) begin start = 0; palavra = w; end
      @(negedge clk);
    end
    chk("latencia", got, TOTAL + 1);
    chk("falhas", falhas, $countones(exp_mapa));
    chk("mapa", mapa_falhas, exp_mapa);
`ifdef CONTROLE_INJECAO_LOG_EN
    chk("res_count", nlog, 16);
`endif
    @(negedge clk);
    chk("pos_busy", busy, 0);
    chk("pos_done", done, 0);
    chk("pos_falhas", falhas, $countones(exp_mapa));
    chk("pos_mapa", mapa_falhas, exp_mapa);
  endtask

  initial begin
    logic [10:0] w;
    logic seen;
    #12;
    chk("rst_outs", {dado_teste, n, erro, busy, done, falhas, mapa_falhas}, 0);
    @(negedge clk);
    rst_n = 1;
    mask = 16'h0000; campanha(11'h5A5, 16'h0000, 0);
    mask = 16'h0080; campanha(11'($urandom), 16'h0080, 0);
    zero_mode = 1; campanha(11'h5A5, 16'hFFFF, 0);
    zero_mode = 0;
    for (int i = 0; i < 3; i++) begin
      mask = 16'($urandom);
      campanha(11'($urandom), mask, (i == 1) ? 10 : 0);
    end
    // cancelar and start together in IDLE: cancelar wins
    @(negedge clk);
    start = 1; cancelar = 1;
    @(negedge clk);
    start = 0; cancelar = 0;
    chk("cancel_vs_start", busy, 0);
    // cancel during step 5 ESPERA keeps the partial results of steps 0..4
    mask = 16'($urandom);
    w = 11'($urandom);
    palavra = w; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5 * PER + 1) @(negedge clk);
    chk("step5_erro", erro, 1);
    chk("step5_n", n, 4);
    cancelar = 1;
    @(negedge clk);
    cancelar = 0;
    chk("cancel_busy", busy, 0);
    chk("cancel_erro", erro, 0);
    chk("cancel_done", done, 0);
    chk("cancel_falhas", falhas, $countones(mask & 16'h800F));
    chk("cancel_mapa", mapa_falhas, mask & 16'h800F);
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= done; end
    chk("cancel_nodone", seen, 0);
    mask = 16'h0000; campanha(11'($urandom), 16'h0000, 0);
    // asynchronous reset mid-campaign
    mask = 16'($urandom);
    palavra = 11'h7FF; start = 1;
    @(negedge clk);
    start = 0;
    repeat (30) @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid", {dado_teste, n, erro, busy, done, falhas, mapa_falhas}, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (TOTAL) begin @(negedge clk); seen |= done | busy; end
    chk("rst_nodone", seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
